servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pwm_pkg.sv | 14 +
 rtl/servo_ramp.sv | 62 ++++++
 rtl/servo_pwm_multi.sv | 89 ++++++++
 tb/tb_servo_pwm_multi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_pkg.sv
// Shared types and default timing for the multi-channel servo PWM block.
// Defaults assume a 100 MHz clock and a 20 ms servo frame.
package servo_pwm_pkg;

    typedef enum logic {
        DIR_CCW = 1'b0,
        DIR_CW  = 1'b1
    } dir_e;

    localparam int DEF_PERIOD_CNT = 2_000_000;
    localparam int DEF_STOP_CNT   = 150_000;
    localparam int DEF_STEP_CNT   = 7_000;

endpackage

// File: rtl/servo_ramp.sv
// One servo channel: holds commanded and in-use pulse widths, slews the in-use
// width once per frame, and produces the registered pwm compare.
module servo_ramp
    import servo_pwm_pkg::*;
#(
    parameter int CNT_W    = 21,
    parameter int STOP_CNT = DEF_STOP_CNT,
    parameter int RAMP_CNT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_width,
    input  logic             tick,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);

    localparam logic [CNT_W-1:0] STOP_W = CNT_W'(STOP_CNT);
    localparam logic [CNT_W-1:0] RAMP_W = CNT_W'(RAMP_CNT);

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;
    logic [CNT_W-1:0] diff;
    logic             rising;

    always_comb begin
        target_d = wr_en ? wr_width : target_q;
        rising   = target_q > active_q;
        diff     = rising ? (target_q - active_q) : (active_q - target_q);
        active_d = active_q;
        // The in-use width only moves on the frame's last cycle, so a pulse
        // is never cut short or stretched mid-frame.
        if (tick) begin
            if (RAMP_CNT == 0 || diff <= RAMP_W) begin
                active_d = target_q;
            end else if (rising) begin
                active_d = active_q + RAMP_W;
            end else begin
                active_d = active_q - RAMP_W;
            end
        end
        pwm_d = en && (cnt < active_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= STOP_W;
            active_q <= STOP_W;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel continuous-rotation servo PWM: shared frame counter, command
// handshake and channel decode feeding one servo_ramp per channel.
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int PERIOD_CNT = DEF_PERIOD_CNT,
    parameter int CNT_W      = 21,
    parameter int STOP_CNT   = DEF_STOP_CNT,
    parameter int STEP_CNT   = DEF_STEP_CNT,
    parameter int LVL_W      = 3,
    parameter int RAMP_CNT   = 0,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CH_W-1:0]  cmd_ch,
    input  logic             cmd_dir,
    input  logic [LVL_W-1:0] cmd_speed,
    output logic             cmd_err,
    output logic [N_CH-1:0]  pwm,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(PERIOD_CNT - 1);
    localparam logic [CNT_W-1:0] STOP_W = CNT_W'(STOP_CNT);
    localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP_CNT);
    localparam logic [CH_W:0]    NCH_W  = (CH_W + 1)'(N_CH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tick;
    logic             accept;
    logic             ch_bad;
    logic [CNT_W-1:0] delta;
    logic [CNT_W-1:0] cmd_width;
    logic [N_CH-1:0]  wr_en;

    always_comb begin
        tick   = en && (cnt_q == LAST_W);
        cnt_d  = (!en || tick) ? '0 : cnt_q + CNT_W'(1);
        accept = cmd_valid && !tick;
        // Out-of-range channel codes exist whenever N_CH is not a power of two.
        ch_bad = {1'b0, cmd_ch} >= NCH_W;
        err_d  = accept && ch_bad;
        delta  = CNT_W'(cmd_speed) * STEP_W;
        cmd_width = (dir_e'(cmd_dir) == DIR_CW) ? (STOP_W + delta) : (STOP_W - delta);
    end

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_en[i] = accept && !ch_bad && (cmd_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign frame_tick = tick;
    assign cmd_ready  = !tick;
    assign cmd_err    = err_q;

    servo_ramp #(
        .CNT_W   (CNT_W),
        .STOP_CNT(STOP_CNT),
        .RAMP_CNT(RAMP_CNT)
    ) u_ch [N_CH-1:0] (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .wr_en   (wr_en),
        .wr_width(cmd_width),
        .tick    (tick),
        .cnt     (cnt_q),
        .pwm     (pwm)
    );

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench: two instances (immediate and ramped) share stimulus; a
// frame-level model predicts per-frame pulse widths and command errors.
module tb_servo_pwm_multi;

    localparam int P     = 100;
    localparam int STOP  = 50;
    localparam int STEP  = 5;
    localparam int NCH   = 3;   // 2-bit cmd_ch so code 3 is a missing channel
    localparam int CW    = 8;
    localparam int LW    = 2;
    localparam int RAMP1 = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           cmd_valid;
    logic [1:0]     cmd_ch;
    logic           cmd_dir;
    logic [LW-1:0]  cmd_speed;
    logic [1:0]     cmd_ready_w, cmd_err_w, frame_tick_w;
    logic [NCH-1:0] pwm0, pwm1;

    always #5 clk = ~clk;

    servo_pwm_multi #(.N_CH(NCH), .PERIOD_CNT(P), .CNT_W(CW), .STOP_CNT(STOP),
        .STEP_CNT(STEP), .LVL_W(LW), .RAMP_CNT(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready_w[0]), .cmd_ch(cmd_ch), .cmd_dir(cmd_dir),
        .cmd_speed(cmd_speed), .cmd_err(cmd_err_w[0]), .pwm(pwm0),
        .frame_tick(frame_tick_w[0]));

    servo_pwm_multi #(.N_CH(NCH), .PERIOD_CNT(P), .CNT_W(CW), .STOP_CNT(STOP),
        .STEP_CNT(STEP), .LVL_W(LW), .RAMP_CNT(RAMP1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready_w[1]), .cmd_ch(cmd_ch), .cmd_dir(cmd_dir),
        .cmd_speed(cmd_speed), .cmd_err(cmd_err_w[1]), .pwm(pwm1),
        .frame_tick(frame_tick_w[1]));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef logic [1:0][NCH-1:0][7:0] exp_t;
    exp_t exp_q[$];
    int   err_q[$];

    int tgt[2][NCH];
    int act[2][NCH];
    int pos;
    int ramp_of[2] = '{0, RAMP1};

    function automatic void chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NCH; i++) begin
                tgt[d][i] = STOP;
                act[d][i] = STOP;
            end
        pos = 0;
        exp_q.delete();
        err_q.delete();
    endtask

    // Inputs for this cycle are already applied; evaluate the frame-level
    // model, check handshake outputs mid-cycle, then advance to the next cycle.
    task automatic model_cycle();
        bit   tick;
        exp_t e;
        int   diff;
        tick = en && (pos == P - 1);
        if (!en) exp_q.delete();
        if (en && pos == 0) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < NCH; i++) e[d][i] = 8'(act[d][i]);
            exp_q.push_back(e);
        end
        if (cmd_valid && !tick) begin
            if (int'(cmd_ch) >= NCH) err_q.push_back(cyc + 1);
            else
                for (int d = 0; d < 2; d++)
                    tgt[d][cmd_ch] = cmd_dir ? STOP + int'(cmd_speed) * STEP
                                             : STOP - int'(cmd_speed) * STEP;
        end
        if (tick) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < NCH; i++) begin
                    diff = tgt[d][i] - act[d][i];
                    if (ramp_of[d] == 0 || (diff <= ramp_of[d] && -diff <= ramp_of[d]))
                        act[d][i] = tgt[d][i];
                    else
                        act[d][i] += (diff > 0) ? ramp_of[d] : -ramp_of[d];
                end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("cmd_ready", int'(cmd_ready_w[d]), int'(!tick));
            chk("frame_tick", int'(frame_tick_w[d]), int'(tick));
        end
        pos = (en && !tick) ? pos + 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) model_cycle();
    endtask

    task automatic goto_pos(int p);
        int guard;
        guard = 0;
        while (pos != p && guard < 3 * P) begin
            model_cycle();
            guard++;
        end
        chk("goto_pos_reached", pos, p);
    endtask

    task automatic send(int ch, bit dir, int sp);
        cmd_valid = 1'b1;
        cmd_ch    = 2'(ch);
        cmd_dir   = dir;
        cmd_speed = LW'(sp);
        model_cycle();
        cmd_valid = 1'b0;
    endtask

    // Monitor: accumulate pwm high cycles per channel and compare against the
    // predicted widths whenever the DUT marks the end of a frame.
    int   hi[2][NCH];
    bit   en_prev = 1'b0;
    exp_t got_e;
    always @(negedge clk) begin
        if (reset === 1'b1 || en !== 1'b1) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < NCH; i++) hi[d][i] = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                hi[0][i] += int'(pwm0[i]);
                hi[1][i] += int'(pwm1[i]);
            end
            if (frame_tick_w[0]) begin
                if (exp_q.size() == 0) begin
                    chk("frame_expect_available", 0, 1);
                end else begin
                    got_e = exp_q.pop_front();
                    for (int d = 0; d < 2; d++)
                        for (int i = 0; i < NCH; i++) begin
                            chk($sformatf("width_dut%0d_ch%0d", d, i), hi[d][i], int'(got_e[d][i]));
                            hi[d][i] = 0;
                        end
                end
            end
        end
        if (!en_prev && reset !== 1'b1) begin
            chk("pwm0_off_after_en_low", int'(pwm0), 0);
            chk("pwm1_off_after_en_low", int'(pwm1), 0);
        end
        if (err_q.size() > 0 && err_q[0] == cyc) begin
            void'(err_q.pop_front());
            chk("cmd_err0_pulse", int'(cmd_err_w[0]), 1);
            chk("cmd_err1_pulse", int'(cmd_err_w[1]), 1);
        end else if (cmd_err_w != 2'b00) begin
            chk("cmd_err_spurious", int'(cmd_err_w), 0);
        end
        en_prev = en;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int off_cnt;
        reset = 1'b1; en = 1'b0; cmd_valid = 1'b0;
        cmd_ch = '0; cmd_dir = 1'b0; cmd_speed = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pwm0", int'(pwm0), 0);
        chk("reset_pwm1", int'(pwm1), 0);
        chk("reset_frame_tick", int'(frame_tick_w), 0);
        chk("reset_cmd_err", int'(cmd_err_w), 0);
        reset = 1'b0;
        en    = 1'b1;

        // Idle frames at the stop width.
        run(3 * P);
        // Command mid-frame takes effect at the next frame.
        goto_pos(20);
        send(0, 1'b1, 3);
        run(2 * P);
        // Command offered on the tick cycle is refused, then taken next cycle.
        goto_pos(P - 1);
        cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_dir = 1'b0; cmd_speed = 2'd1;
        model_cycle();
        model_cycle();
        cmd_valid = 1'b0;
        run(2 * P);
        // Ramped channel walks 50 -> 46 -> 42 -> 38 -> 35 on dut1.
        goto_pos(10);
        send(1, 1'b0, 3);
        run(5 * P);
        // Missing channel: error pulse, no width change.
        goto_pos(40);
        send(3, 1'b1, 2);
        run(2 * P);
        // Disable mid-pulse.
        goto_pos(10);
        en = 1'b0;
        model_cycle();
        chk("en_low_pwm0", int'(pwm0), 0);
        chk("en_low_pwm1", int'(pwm1), 0);
        run(7);
        en = 1'b1;
        run(2 * P);

        // Randomized commands with occasional enable drops.
        off_cnt = 0;
        for (int k = 0; k < 25 * P; k++) begin
            cmd_valid = ($urandom_range(0, 14) == 0);
            cmd_ch    = 2'($urandom_range(0, 3));
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_speed = LW'($urandom_range(0, 3));
            if (off_cnt > 0) begin
                off_cnt--;
                en = (off_cnt == 0);
            end else if ($urandom_range(0, 599) == 0) begin
                off_cnt = $urandom_range(1, 5);
                en = 1'b0;
            end
            model_cycle();
        end
        cmd_valid = 1'b0;
        en = 1'b1;
        run(2 * P);

        // Asynchronous reset mid-frame.
        goto_pos(30);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_pwm0", int'(pwm0), 0);
        chk("async_reset_pwm1", int'(pwm1), 0);
        chk("async_reset_tick", int'(frame_tick_w), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(3 * P);

        cmd_valid = 1'b0;
        run(5);
        chk("err_queue_drained", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
